// File: rtl/piso_reg_reader.sv
// Parallel-in serial-out unload stage: captures one W-bit word through a valid/ready load
// handshake, then shifts it out one bit per accepted beat. Optional parity beat: PISO_PARITY_EN.
module piso_reg_reader #(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] d,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         sout_last,
    output logic         busy
);

    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
    localparam logic [1:0]     ST_IDLE  = 2'd0;
    localparam logic [1:0]     ST_SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0]     ST_PAR   = 2'd2;
`endif

    logic [1:0]    state_r, state_s;
    logic [W-1:0]  shreg_r, shreg_s, shifted_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          sout_r, sout_s;
    logic          sout_valid_r, sout_valid_s;
    logic          sout_last_r, sout_last_s;
    logic          busy_r, busy_s;
    logic          load_ready_r, load_ready_s;
    logic          load_xfer_s, bit_xfer_s;
`ifdef PISO_PARITY_EN
    logic          parity_r, parity_s;

    function automatic logic even_parity(input logic [W-1:0] w);
        return ^w;
    endfunction
`endif

    function automatic logic first_bit(input logic [W-1:0] w);
        return MSB_FIRST ? w[W-1] : w[0];
    endfunction

    function automatic logic [W-1:0] shift_once(input logic [W-1:0] w);
        return MSB_FIRST ? {w[W-2:0], 1'b0} : {1'b0, w[W-1:1]};
    endfunction

    // Next-state logic; ce gating is applied at the register stage.
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        cnt_s        = cnt_r;
        sout_s       = sout_r;
        sout_valid_s = sout_valid_r;
        sout_last_s  = sout_last_r;
        busy_s       = busy_r;
        load_ready_s = load_ready_r;
`ifdef PISO_PARITY_EN
        parity_s     = parity_r;
`endif
        shifted_s    = shift_once(shreg_r);
        load_xfer_s  = load_valid & load_ready_r;
        bit_xfer_s   = sout_valid_r & sout_ready;

        case (state_r)
            ST_IDLE: begin
                if (load_xfer_s) begin
                    state_s      = ST_SHIFT;
                    shreg_s      = d;
                    cnt_s        = '0;
                    load_ready_s = 1'b0;
                    sout_valid_s = 1'b1;
                    busy_s       = 1'b1;
                    sout_s       = first_bit(d);
                    sout_last_s  = 1'b0;
`ifdef PISO_PARITY_EN
                    parity_s     = even_parity(d);
`endif
                end else begin
                    load_ready_s = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_xfer_s && (cnt_r == CNT_LAST)) begin
                    cnt_s = '0;
`ifdef PISO_PARITY_EN
                    state_s     = ST_PAR;
                    sout_s      = parity_r;
                    sout_last_s = 1'b1;
`else
                    state_s      = ST_IDLE;
                    sout_s       = 1'b0;
                    sout_valid_s = 1'b0;
                    sout_last_s  = 1'b0;
                    busy_s       = 1'b0;
                    load_ready_s = 1'b1;
`endif
                end else if (bit_xfer_s) begin
                    shreg_s     = shifted_s;
                    cnt_s       = cnt_r + CW'(1);
                    sout_s      = first_bit(shifted_s);
                    sout_last_s = ((cnt_r + CW'(1)) == CNT_LAST);
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef PISO_PARITY_EN
            ST_PAR: begin
                if (bit_xfer_s) begin
                    state_s      = ST_IDLE;
                    sout_s       = 1'b0;
                    sout_valid_s = 1'b0;
                    sout_last_s  = 1'b0;
                    busy_s       = 1'b0;
                    load_ready_s = 1'b1;
                end else begin
                    state_s = ST_PAR;
                end
            end
`endif
            default: begin
                state_s      = ST_IDLE;
                cnt_s        = '0;
                sout_s       = 1'b0;
                sout_valid_s = 1'b0;
                sout_last_s  = 1'b0;
                busy_s       = 1'b0;
                load_ready_s = 1'b0;
            end
        endcase
    end

    // State registers: async reset, every update qualified by ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shreg_r      <= '0;
            cnt_r        <= '0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_r     <= 1'b0;
`endif
        end else if (ce) begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            cnt_r        <= cnt_s;
            sout_r       <= sout_s;
            sout_valid_r <= sout_valid_s;
            sout_last_r  <= sout_last_s;
            busy_r       <= busy_s;
            load_ready_r <= load_ready_s;
`ifdef PISO_PARITY_EN
            parity_r     <= parity_s;
`endif
        end
    end

    assign load_ready = load_ready_r;
    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign sout_last  = sout_last_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_piso_reg_reader.sv
// Bench for piso_reg_reader: an MSB-first and an LSB-first instance share stimulus and are
// compared against a queue-of-expected-bits model. Honours PISO_PARITY_EN like the design.
module tb_piso_reg_reader;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ce = 1'b0;
    logic [W-1:0] d = '0;
    logic         load_valid = 1'b0;
    logic         sout_ready = 1'b0;
    logic         m_lr, m_sout, m_sv, m_sl, m_busy;
    logic         l_lr, l_sout, l_sv, l_sl, l_busy;

    int   n_checks = 0;
    int   n_pass = 0;
    logic qm[$];
    logic ql[$];
    logic m_ready = 1'b0;

    always #5 clk = ~clk;

    piso_reg_reader #(.W(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(d), .load_valid(load_valid),
        .load_ready(m_lr), .sout(m_sout), .sout_valid(m_sv), .sout_ready(sout_ready),
        .sout_last(m_sl), .busy(m_busy)
    );

    piso_reg_reader #(.W(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(d), .load_valid(load_valid),
        .load_ready(l_lr), .sout(l_sout), .sout_valid(l_sv), .sout_ready(sout_ready),
        .sout_last(l_sl), .busy(l_busy)
    );

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            qm.push_back(w[W-1-i]);
            ql.push_back(w[i]);
        end
`ifdef PISO_PARITY_EN
        qm.push_back(^w);
        ql.push_back(^w);
`endif
    endfunction

    // Expected {sout, sout_valid, sout_last, busy, load_ready} from the remaining-bit queue.
    function automatic logic [4:0] exp_vec(input logic q[$]);
        if (q.size() > 0)
            return {q[0], 1'b1, (q.size() == 1), 1'b1, m_ready};
        else
            return {4'b0000, m_ready};
    endfunction

    // Advance one clock edge and update the model with the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            qm.delete();
            ql.delete();
            m_ready = 1'b0;
        end else if (ce) begin
            if (qm.size() == 0) begin
                if (load_valid && m_ready) begin
                    push_word(d);
                    m_ready = 1'b0;
                end else begin
                    m_ready = 1'b1;
                end
            end else if (sout_ready) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                if (qm.size() == 0) m_ready = 1'b1;
            end
        end
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ce = 1'b1;
        load_valid = 1'b0;
        sout_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_lr && l_lr) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst_n = 1'b0;
        ce = 1'b0;
        repeat (2) step();
        obs = {m_lr, m_sout, m_sv, m_sl, m_busy, l_lr, l_sout, l_sv, l_sl, l_busy};
        n_checks++;
        if (obs !== 10'd0) $display("FAIL reset_state got=%b exp=%b", obs, 10'd0); else n_pass++;
        rst_n = 1'b1;
        ce = 1'b1;
        #1;
        n_checks++;
        if ({m_lr, l_lr} !== 2'b00) $display("FAIL ready_before_edge got=%b exp=00", {m_lr, l_lr}); else n_pass++;
        step();
        n_checks++;
        if ({m_lr, l_lr} !== 2'b11) $display("FAIL ready_after_edge got=%b exp=11", {m_lr, l_lr}); else n_pass++;
        d = W'($urandom);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        sout_ready = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        qm.delete();
        ql.delete();
        m_ready = 1'b0;
        #1;
        obs = {m_lr, m_sout, m_sv, m_sl, m_busy, l_lr, l_sout, l_sv, l_sl, l_busy};
        n_checks++;
        if (obs !== 10'd0) $display("FAIL async_reset_midword got=%b exp=%b", obs, 10'd0); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        obs = {m_lr, m_sout, m_sv, m_sl, m_busy, l_lr, l_sout, l_sv, l_sl, l_busy};
        n_checks++;
        if (obs !== 10'b10000_10000) $display("FAIL post_reset_idle got=%b exp=%b", obs, 10'b10000_10000); else n_pass++;
    endtask

    // Directed word: exp_m / exp_l list data bits then the parity bit, first beat in bit 4.
    task automatic test_word(input logic [W-1:0] w, input logic [4:0] exp_m, input logic [4:0] exp_l, input bit toggle);
        bit ok;
        int beat;
        int cyc;
        logic rdy;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL word_wait_idle got=timeout exp=idle"); else n_pass++;
        d = w;
        load_valid = 1'b1;
        sout_ready = 1'b1;
        step();
        load_valid = 1'b0;
        d = W'($urandom);
        beat = 0;
        cyc = 0;
        while (beat < NB && cyc < 40) begin
            n_checks++;
            if ({m_sv, m_sout, m_sl} !== {1'b1, exp_m[4-beat], (beat == NB-1)})
                $display("FAIL word_msb beat=%0d got=%b exp=%b", beat, {m_sv, m_sout, m_sl},
                         {1'b1, exp_m[4-beat], (beat == NB-1)});
            else n_pass++;
            n_checks++;
            if ({l_sv, l_sout, l_sl} !== {1'b1, exp_l[4-beat], (beat == NB-1)})
                $display("FAIL word_lsb beat=%0d got=%b exp=%b", beat, {l_sv, l_sout, l_sl},
                         {1'b1, exp_l[4-beat], (beat == NB-1)});
            else n_pass++;
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            sout_ready = rdy;
            step();
            if (rdy) beat++;
            cyc++;
        end
        n_checks++;
        if (beat != NB) $display("FAIL word_beats got=%0d exp=%0d", beat, NB); else n_pass++;
        n_checks++;
        if ({m_sv, m_busy, m_lr, l_sv, l_busy, l_lr} !== 6'b001001)
            $display("FAIL word_idle_after got=%b exp=001001", {m_sv, m_busy, m_lr, l_sv, l_busy, l_lr});
        else n_pass++;
    endtask

    task automatic test_ce_freeze();
        bit ok;
        logic [4:0] em, el;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL freeze_wait_idle got=timeout exp=idle"); else n_pass++;
        d = W'($urandom);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        sout_ready = 1'b1;
        step();
        ce = 1'b0;
        for (int i = 0; i < 3 + NB + 2; i++) begin
            if (i == 3) ce = 1'b1;
            step();
            em = exp_vec(qm);
            el = exp_vec(ql);
            n_checks++;
            if ({m_sout & m_sv, m_sv, m_sl, m_busy, m_lr} !== em)
                $display("FAIL ce_freeze_msb cyc=%0d got=%b exp=%b", i, {m_sout & m_sv, m_sv, m_sl, m_busy, m_lr}, em);
            else n_pass++;
            n_checks++;
            if ({l_sout & l_sv, l_sv, l_sl, l_busy, l_lr} !== el)
                $display("FAIL ce_freeze_lsb cyc=%0d got=%b exp=%b", i, {l_sout & l_sv, l_sv, l_sl, l_busy, l_lr}, el);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_load();
        bit ok;
        logic [4:0] em, el;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("FAIL ignore_wait_idle got=timeout exp=idle"); else n_pass++;
        d = W'($urandom_range(0, 14));
        load_valid = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            d = 4'hF;
            load_valid = 1'b1;
            sout_ready = 1'($urandom);
            step();
            em = exp_vec(qm);
            el = exp_vec(ql);
            n_checks++;
            if ({m_sout & m_sv, m_sv, m_sl, m_busy, m_lr} !== em)
                $display("FAIL ignore_load_msb cyc=%0d got=%b exp=%b", i, {m_sout & m_sv, m_sv, m_sl, m_busy, m_lr}, em);
            else n_pass++;
            n_checks++;
            if ({l_sout & l_sv, l_sv, l_sl, l_busy, l_lr} !== el)
                $display("FAIL ignore_load_lsb cyc=%0d got=%b exp=%b", i, {l_sout & l_sv, l_sv, l_sl, l_busy, l_lr}, el);
            else n_pass++;
            if (qm.size() == 0) break;
        end
        load_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] em, el;
        for (int i = 0; i < 400; i++) begin
            ce = (($urandom % 8) != 0);
            load_valid = 1'($urandom);
            d = W'($urandom);
            sout_ready = 1'($urandom);
            step();
            em = exp_vec(qm);
            el = exp_vec(ql);
            n_checks++;
            if ({m_sout & m_sv, m_sv, m_sl, m_busy, m_lr} !== em)
                $display("FAIL random_msb cyc=%0d got=%b exp=%b", i, {m_sout & m_sv, m_sv, m_sl, m_busy, m_lr}, em);
            else n_pass++;
            n_checks++;
            if ({l_sout & l_sv, l_sv, l_sl, l_busy, l_lr} !== el)
                $display("FAIL random_lsb cyc=%0d got=%b exp=%b", i, {l_sout & l_sv, l_sv, l_sl, l_busy, l_lr}, el);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_word(4'b1011, 5'b10111, 5'b11011, 1'b0);
        test_word(4'b1011, 5'b10111, 5'b11011, 1'b1);
        test_word(4'b0111, 5'b01111, 5'b11101, 1'b0);
        test_ce_freeze();
        test_ignore_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
